// File: rtl/mc_apb_cfg.sv
// rtl/mc_apb_cfg.sv - APB register block holding memory-controller timing and refresh configuration
module mc_apb_cfg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  apb_pclk,
    input  logic                  apb_prst,
    input  logic                  apb_psel,
    input  logic                  apb_pwrite,
    input  logic                  apb_penable,
    input  logic [ADDR_WIDTH-1:0] apb_paddr,
    input  logic [DATA_WIDTH-1:0] apb_pwdata,
    output logic                  apb_pready,
    output logic [DATA_WIDTH-1:0] apb_prdata,
    output logic                  mc_en,
    output logic [1:0]            axi2array_rw_prio,
    output logic [7:0]            array_tRAS,
    output logic [7:0]            array_tRP,
    output logic [7:0]            array_tRC,
    output logic [7:0]            array_tRCD_WR,
    output logic [7:0]            array_tRCD_RD,
    output logic [7:0]            array_tWR,
    output logic [7:0]            array_tRTP,
    output logic [24:0]           array_rf_period_0,
    output logic [24:0]           array_rf_period_1,
    output logic                  array_rf_period_sel
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_EN     = ADDR_WIDTH'('h00);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PRIO   = ADDR_WIDTH'('h04);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TIM0   = ADDR_WIDTH'('h08);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TIM1   = ADDR_WIDTH'('h0C);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RF0    = ADDR_WIDTH'('h10);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RF1    = ADDR_WIDTH'('h14);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RF_SEL = ADDR_WIDTH'('h18);

    logic                  wr_en;
    logic                  rd_setup;
    logic [DATA_WIDTH-1:0] rd_mux;

    assign apb_pready = 1'b1;
    assign wr_en      = apb_psel & apb_penable & apb_pwrite;
    // Read data is sampled in the setup phase so it is stable for the whole access phase.
    assign rd_setup   = apb_psel & ~apb_penable & ~apb_pwrite;

    always_comb begin
        rd_mux = '0;
        case (apb_paddr)
            ADDR_EN:     rd_mux[0]     = mc_en;
            ADDR_PRIO:   rd_mux[1:0]   = axi2array_rw_prio;
            ADDR_TIM0:   rd_mux[23:0]  = {array_tRC, array_tRP, array_tRAS};
            ADDR_TIM1:   rd_mux[31:0]  = {array_tRTP, array_tWR, array_tRCD_RD, array_tRCD_WR};
            ADDR_RF0:    rd_mux[24:0]  = array_rf_period_0;
            ADDR_RF1:    rd_mux[24:0]  = array_rf_period_1;
            ADDR_RF_SEL: rd_mux[0]     = array_rf_period_sel;
            default:     rd_mux        = '0;
        endcase
    end

    always_ff @(posedge apb_pclk or posedge apb_prst) begin
        if (apb_prst) begin
            apb_prdata          <= '0;
            mc_en               <= 1'b0;
            axi2array_rw_prio   <= '0;
            array_tRAS          <= '0;
            array_tRP           <= '0;
            array_tRC           <= '0;
            array_tRCD_WR       <= '0;
            array_tRCD_RD       <= '0;
            array_tWR           <= '0;
            array_tRTP          <= '0;
            array_rf_period_0   <= '0;
            array_rf_period_1   <= '0;
            array_rf_period_sel <= 1'b0;
        end else begin
            if (rd_setup) begin
                apb_prdata <= rd_mux;
            end
            if (wr_en) begin
                case (apb_paddr)
                    ADDR_EN:     mc_en             <= apb_pwdata[0];
                    ADDR_PRIO:   axi2array_rw_prio <= apb_pwdata[1:0];
                    ADDR_TIM0: begin
                        array_tRAS <= apb_pwdata[7:0];
                        array_tRP  <= apb_pwdata[15:8];
                        array_tRC  <= apb_pwdata[23:16];
                    end
                    ADDR_TIM1: begin
                        array_tRCD_WR <= apb_pwdata[7:0];
                        array_tRCD_RD <= apb_pwdata[15:8];
                        array_tWR     <= apb_pwdata[23:16];
                        array_tRTP    <= apb_pwdata[31:24];
                    end
                    ADDR_RF0:    array_rf_period_0   <= apb_pwdata[24:0];
                    ADDR_RF1:    array_rf_period_1   <= apb_pwdata[24:0];
                    ADDR_RF_SEL: array_rf_period_sel <= apb_pwdata[0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mc_apb_cfg.sv
// tb/tb_mc_apb_cfg.sv - directed table-driven bench for mc_apb_cfg
module tb_mc_apb_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, pwrite, penable;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        mc_en;
    logic [1:0]  prio;
    logic [7:0]  t_ras, t_rp, t_rc, t_rcd_wr, t_rcd_rd, t_wr, t_rtp;
    logic [24:0] rf0, rf1;
    logic        rf_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_apb_cfg #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .apb_pclk            (clk),
        .apb_prst            (rst),
        .apb_psel            (psel),
        .apb_pwrite          (pwrite),
        .apb_penable         (penable),
        .apb_paddr           (paddr),
        .apb_pwdata          (pwdata),
        .apb_pready          (pready),
        .apb_prdata          (prdata),
        .mc_en               (mc_en),
        .axi2array_rw_prio   (prio),
        .array_tRAS          (t_ras),
        .array_tRP           (t_rp),
        .array_tRC           (t_rc),
        .array_tRCD_WR       (t_rcd_wr),
        .array_tRCD_RD       (t_rcd_rd),
        .array_tWR           (t_wr),
        .array_tRTP          (t_rtp),
        .array_rf_period_0   (rf0),
        .array_rf_period_1   (rf1),
        .array_rf_period_sel (rf_sel)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Both tasks start and end at posedge+1; consecutive calls run back to back.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        @(posedge clk); #1 penable = 1'b1;
        d = prdata;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    function automatic logic [31:0] reg_mask(input int idx);
        case (idx)
            0: return 32'h0000_0001;
            1: return 32'h0000_0003;
            2: return 32'h00FF_FFFF;
            3: return 32'hFFFF_FFFF;
            4: return 32'h01FF_FFFF;
            5: return 32'h01FF_FFFF;
            6: return 32'h0000_0001;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] w;

        rst = 1'b1; psel = 1'b0; pwrite = 1'b0; penable = 1'b0; paddr = '0; pwdata = '0;

        for (int i = 0; i < 7; i++) tbl.push_back('{1'b0, 8'(4 * i), 32'h0, 32'h0});
        tbl.push_back('{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{1'b1, 8'h10, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{1'b1, 8'h18, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{1'b0, 8'h00, 32'h0, 32'h0000_0001});
        tbl.push_back('{1'b0, 8'h04, 32'h0, 32'h0000_0003});
        tbl.push_back('{1'b0, 8'h08, 32'h0, 32'h00FF_FFFF});
        tbl.push_back('{1'b0, 8'h10, 32'h0, 32'h01FF_FFFF});
        tbl.push_back('{1'b0, 8'h18, 32'h0, 32'h0000_0001});
        tbl.push_back('{1'b1, 8'h0C, 32'h4433_2211, 32'h0});
        tbl.push_back('{1'b0, 8'h0C, 32'h0, 32'h4433_2211});
        tbl.push_back('{1'b1, 8'h1C, 32'h1234_5678, 32'h0});
        tbl.push_back('{1'b1, 8'h02, 32'h1234_5678, 32'h0});
        tbl.push_back('{1'b0, 8'h1C, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 8'h02, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 8'h14, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 8'h00, 32'h0, 32'h0000_0001});

        repeat (3) @(posedge clk);
        check("pready_in_reset", {31'b0, pready}, 32'h1);
        #1 rst = 1'b0;

        check("reset_cfg_lo", {mc_en, prio, t_ras, t_rp, t_rc, t_rcd_wr[4:0]}, 32'h0);
        check("reset_cfg_hi", {t_rcd_wr[7:5], t_rcd_rd, t_wr, t_rtp, rf_sel}, 32'h0);
        check("reset_rf0", {7'b0, rf0}, 32'h0);
        check("reset_rf1", {7'b0, rf1}, 32'h0);
        check("reset_prdata", prdata, 32'h0);

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                apb_write(tbl[i].addr, tbl[i].wdata);
            end else begin
                apb_read(tbl[i].addr, rd);
                check($sformatf("vec%0d_rd_%h", i, tbl[i].addr), rd, tbl[i].exp);
            end
        end

        check("map_tRCD_WR", {24'b0, t_rcd_wr}, 32'h11);
        check("map_tRCD_RD", {24'b0, t_rcd_rd}, 32'h22);
        check("map_tWR", {24'b0, t_wr}, 32'h33);
        check("map_tRTP", {24'b0, t_rtp}, 32'h44);
        check("unmapped_en_prio", {29'b0, mc_en, prio}, 32'h7);
        check("unmapped_tim0", {8'b0, t_rc, t_rp, t_ras}, 32'h00FF_FFFF);
        check("unmapped_rf0", {7'b0, rf0}, 32'h01FF_FFFF);
        check("unmapped_rf1", {7'b0, rf1}, 32'h0);
        check("unmapped_sel", {31'b0, rf_sel}, 32'h1);

        for (int i = 0; i < 7; i++) begin
            w = $urandom;
            apb_write(8'(4 * i), w);
            apb_read(8'(4 * i), rd);
            @(negedge clk);
            check($sformatf("rand%0d_prdata", i), prdata, w & reg_mask(i));
            @(posedge clk); #1;
        end

        apb_write(8'h00, 32'h1);
        check("pre_rst_mc_en", {31'b0, mc_en}, 32'h1);
        apb_read(8'h00, rd);
        check("pre_rst_prdata", prdata, 32'h1);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 8'h00; pwdata = 32'h0;
        @(posedge clk); #1 penable = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("midrst_mc_en", {31'b0, mc_en}, 32'h0);
        check("midrst_prdata", prdata, 32'h0);
        check("midrst_pready", {31'b0, pready}, 32'h1);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0;
        apb_write(8'h04, 32'h2);
        check("post_rst_prio", {30'b0, prio}, 32'h2);
        apb_read(8'h04, rd);
        check("post_rst_rd", rd, 32'h2);
        check("post_rst_rf0", {7'b0, rf0}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
